// File: rtl/mapper_pkg.sv
// Shared mapper types and constants: bank register layout, mapper type codes,
// invalid-address fill and the per-window reset bank value.
package mapper_pkg;

  localparam int unsigned ADDR_W = 27;

  typedef enum logic [3:0] {
    MAPPER_NONE,
    MAPPER_ASCII8,
    MAPPER_ASCII16,
    MAPPER_KONAMI,
    MAPPER_KONAMI_SCC,
    MAPPER_GENERIC_BANKED
  } mapper_type_e;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = '1;

  typedef struct packed {
    logic       sram_flag;
    logic       unmapped;
    logic [7:0] blk;
  } bank_reg_t;

  localparam bank_reg_t BANK_UNMAPPED = '{sram_flag: 1'b0, unmapped: 1'b1, blk: 8'h00};

  // Window w powers up on block (w mod nr); an empty ROM leaves every window unmapped.
  function automatic bank_reg_t bank_reset_val(input int unsigned w, input logic [8:0] nr);
    bank_reg_t r;
    if (nr == 9'd0) begin
      r = BANK_UNMAPPED;
    end else begin
      r     = '0;
      r.blk = 8'(w % 32'(nr));
    end
    return r;
  endfunction

endpackage

// File: rtl/mapper_block_calc.sv
// Combinational ROM block math: block count (saturating at 256), wrap mask and
// the bank register value a written data byte resolves to.
module mapper_block_calc
  import mapper_pkg::*;
#(
  parameter int unsigned BANK_BITS = 14
) (
  input  logic [ADDR_W-1:0] rom_size_i,
  input  logic [7:0]        data_i,
  output logic [8:0]        nr_o,
  output bank_reg_t         blk_reg_o
);

  logic [ADDR_W-1:0] blocks;
  logic [8:0]        mask;
  logic [8:0]        data9;
  logic [8:0]        sel;

  always_comb begin
    blocks    = rom_size_i >> BANK_BITS;
    nr_o      = (blocks > ADDR_W'(256)) ? 9'd256 : blocks[8:0];
    mask      = nr_o - 9'd1;
    data9     = {1'b0, data_i};
    sel       = (data9 < nr_o) ? data9 : (data9 & mask);
    blk_reg_o = '0;
    blk_reg_o.unmapped = !(sel < nr_o);
    blk_reg_o.blk      = blk_reg_o.unmapped ? 8'h00 : sel[7:0];
  end

endmodule

// File: rtl/mapper_generic_banked.sv
// Generic banked ROM mapper: per-instance, per-window bank registers and a
// zero-latency ROM/SRAM read decode. Optional SRAM banking: MAPPER_SRAM_EN.
module mapper_generic_banked
  import mapper_pkg::*;
#(
  parameter int unsigned BANK_BITS   = 14,
  parameter int unsigned FIRST_PAGE  = 1,
  parameter int unsigned NUM_WINDOWS = 2,
  parameter int unsigned NUM_IDS     = 2,
  parameter int unsigned SRAM_BIT    = 7
) (
  input  logic                                          clk,
  input  logic                                          reset_n,
  input  logic                                          enable,
  input  logic [(NUM_IDS > 1 ? $clog2(NUM_IDS) : 1)-1:0] blk_id,
  input  logic [ADDR_W-1:0]                             rom_size,
  input  logic [15:0]                                   cpu_addr,
  input  logic [7:0]                                    cpu_data,
  input  logic                                          cpu_mreq,
  input  logic                                          cpu_rd,
  input  logic                                          cpu_wr,
  input  logic                                          cpu_req,
  output logic                                          ram_cs,
  output logic [ADDR_W-1:0]                             ram_addr,
  output logic                                          sram_cs,
  output logic [BANK_BITS-1:0]                          sram_addr
);

  localparam int unsigned PAGE_W = 16 - BANK_BITS;

`ifdef MAPPER_SRAM_EN
  localparam logic SRAM_FEATURE = 1'b1;
`else
  localparam logic SRAM_FEATURE = 1'b0;
`endif

  bank_reg_t bank_q [NUM_IDS][NUM_WINDOWS];
  bank_reg_t rst_val [NUM_WINDOWS];
  bank_reg_t calc_reg;
  bank_reg_t new_reg;
  bank_reg_t cur;
  logic      wr_q;
  logic [8:0]        nr;
  logic [PAGE_W-1:0] page;
  logic [31:0]       page_u;
  logic [31:0]       win;
  logic              in_range;
  logic              id_ok;
  logic              mapped;
  logic              reg_sel;
  logic              wstb;
  logic              wr_en;

  mapper_block_calc #(
    .BANK_BITS (BANK_BITS)
  ) u_calc (
    .rom_size_i (rom_size),
    .data_i     (cpu_data),
    .nr_o       (nr),
    .blk_reg_o  (calc_reg)
  );

  assign page = cpu_addr[15:BANK_BITS];

  always_comb begin
    page_u   = 32'(page);
    in_range = (page_u >= FIRST_PAGE) && (page_u < FIRST_PAGE + NUM_WINDOWS);
    win      = page_u - FIRST_PAGE;
    id_ok    = 32'(blk_id) < NUM_IDS;
    mapped   = enable & cpu_mreq & in_range & id_ok;
    reg_sel  = ~SRAM_FEATURE | (cpu_addr[BANK_BITS-1 -: 2] == 2'b10);
    wstb     = mapped & cpu_wr & cpu_req;
    wr_en    = wstb & ~wr_q & reg_sel;
    new_reg           = calc_reg;
    new_reg.sram_flag = SRAM_FEATURE & cpu_data[SRAM_BIT];
  end

  always_comb begin
    for (int unsigned w = 0; w < NUM_WINDOWS; w++) begin
      rst_val[w] = bank_reset_val(w, nr);
    end
  end

  // Explicit match loop instead of direct indexing keeps out-of-range ids/pages harmless.
  always_comb begin
    cur = BANK_UNMAPPED;
    for (int unsigned i = 0; i < NUM_IDS; i++) begin
      for (int unsigned w = 0; w < NUM_WINDOWS; w++) begin
        if (32'(blk_id) == i && win == w) cur = bank_q[i][w];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_IDS; i++) begin
        for (int unsigned w = 0; w < NUM_WINDOWS; w++) begin
          bank_q[i][w] <= rst_val[w];
        end
      end
    end else begin
      wr_q <= wstb;
      for (int unsigned i = 0; i < NUM_IDS; i++) begin
        for (int unsigned w = 0; w < NUM_WINDOWS; w++) begin
          if (wr_en && 32'(blk_id) == i && win == w) bank_q[i][w] <= new_reg;
        end
      end
    end
  end

  // Outputs are gated by reset_n so they drop the instant reset asserts.
  always_comb begin
    ram_cs    = reset_n & mapped & cpu_rd & ~cur.unmapped & ~cur.sram_flag;
    ram_addr  = ram_cs ? ((ADDR_W'(cur.blk) << BANK_BITS) | ADDR_W'(cpu_addr[BANK_BITS-1:0]))
                       : ADDR_INVALID;
    sram_cs   = SRAM_FEATURE & reset_n & mapped & cur.sram_flag
                & (cpu_rd | (cpu_wr & cpu_req & ~reg_sel));
    sram_addr = sram_cs ? cpu_addr[BANK_BITS-1:0] : '0;
  end

endmodule

// File: tb/tb_mapper_generic_banked.sv
// Scoreboard bench for mapper_generic_banked: a default-parameter instance and an
// 8KB-bank instance share the CPU bus; expectations are queued and checked on negedge.
module tb_mapper_generic_banked;

`ifdef MAPPER_SRAM_EN
  localparam bit SRAM_ON = 1'b1;
`else
  localparam bit SRAM_ON = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        blk_id;
  logic [26:0] rom_size;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_mreq, cpu_rd, cpu_wr, cpu_req;

  logic        ram_cs_a, sram_cs_a, ram_cs_b, sram_cs_b;
  logic [26:0] ram_addr_a, ram_addr_b;
  logic [13:0] sram_addr_a;
  logic [12:0] sram_addr_b;

  mapper_generic_banked dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable), .blk_id(blk_id), .rom_size(rom_size),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_mreq(cpu_mreq), .cpu_rd(cpu_rd),
    .cpu_wr(cpu_wr), .cpu_req(cpu_req), .ram_cs(ram_cs_a), .ram_addr(ram_addr_a),
    .sram_cs(sram_cs_a), .sram_addr(sram_addr_a)
  );

  mapper_generic_banked #(
    .BANK_BITS(13), .FIRST_PAGE(2), .NUM_WINDOWS(4), .NUM_IDS(2), .SRAM_BIT(7)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(enable), .blk_id(blk_id), .rom_size(rom_size),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_mreq(cpu_mreq), .cpu_rd(cpu_rd),
    .cpu_wr(cpu_wr), .cpu_req(cpu_req), .ram_cs(ram_cs_b), .ram_addr(ram_addr_b),
    .sram_cs(sram_cs_b), .sram_addr(sram_addr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          sel;
    logic [63:0] val;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur_e;
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic logic [63:0] mk(input logic cs, input logic [26:0] a,
                                     input logic scs, input logic [13:0] sa);
    return {21'b0, cs, a, scs, sa};
  endfunction

  function automatic logic [63:0] hit(input logic [26:0] a);
    return mk(1'b1, a, 1'b0, 14'h0);
  endfunction

  function automatic logic [63:0] miss();
    return mk(1'b0, 27'h7FF_FFFF, 1'b0, 14'h0);
  endfunction

  function automatic logic [63:0] sram_hit(input logic [13:0] sa);
    return mk(1'b0, 27'h7FF_FFFF, 1'b1, sa);
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur_e = exp_q.pop_front();
      if (cur_e.sel)
        check_eq(cur_e.tag, mk(ram_cs_b, ram_addr_b, sram_cs_b, {1'b0, sram_addr_b}), cur_e.val);
      else
        check_eq(cur_e.tag, mk(ram_cs_a, ram_addr_a, sram_cs_a, sram_addr_a), cur_e.val);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bus(input logic [15:0] a, input logic [7:0] d, input logic r, input logic w);
    cpu_addr = a;
    cpu_data = d;
    cpu_rd   = r;
    cpu_wr   = w;
    cpu_req  = r | w;
    cpu_mreq = r | w;
  endtask

  task automatic expect_out(input bit sel, input logic [63:0] v, input string tag);
    exp_t e;
    e.sel = sel;
    e.val = v;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic rd(input bit sel, input logic [15:0] a, input logic [63:0] v, input string tag);
    set_bus(a, 8'h00, 1'b1, 1'b0);
    expect_out(sel, v, tag);
    step();
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    set_bus(a, d, 1'b0, 1'b1);
    step();
    set_bus(16'h0000, 8'h00, 1'b0, 1'b0);
    step();
  endtask

  task automatic reset_pulse();
    set_bus(16'h0000, 8'h00, 1'b0, 1'b0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    reset_n  = 1'b0;
    enable   = 1'b1;
    blk_id   = 1'b0;
    rom_size = 27'h20000;
    set_bus(16'h0000, 8'h00, 1'b0, 1'b0);
    step();
    rd(0, 16'h4000, miss(), "rst_gate");
    reset_n = 1'b1;
    step();
    rd(0, 16'h4000, hit(27'h0000000), "rst_w0");
    rd(0, 16'h8000, hit(27'h0004000), "rst_w1");

    // held strobe: only the first cycle captures
    set_bus(16'hA000, 8'h05, 1'b0, 1'b1);
    step();
    cpu_data = 8'h06;
    step();
    step();
    rd(0, 16'h8123, hit(27'h0014123), "hold_wr");

    // same-cycle write and read: read sees old bank
    set_bus(16'hA000, 8'h02, 1'b1, 1'b1);
    expect_out(0, hit(27'h0016000), "rw_old");
    step();
    rd(0, 16'hA000, hit(27'h000A000), "rw_new");

    wr(16'h6000, 8'h0B);
    rd(0, 16'h4000, hit(27'h000C000), "wrap128_0B");
    rom_size = 27'h18000;
    wr(16'h6000, 8'h09);
    rd(0, 16'h4000, hit(27'h0004000), "wrap96_09");
    wr(16'h6000, 8'h0E);
    rd(0, 16'h4000, hit(27'h0010000), "wrap96_0E");
    wr(16'h6000, 8'h07);
    rd(0, 16'h4000, hit(27'h0014000), "wrap96_07");
    wr(16'h6000, 8'h03);
    rd(0, 16'h4000, hit(27'h000C000), "wrap96_03");
    wr(16'h6000, 8'hFF);
    rd(0, 16'h4000, SRAM_ON ? sram_hit(14'h0000) : hit(27'h0014000), "wrap96_FF");
    rom_size = 27'h08000;
    wr(16'hA000, 8'h02);
    rd(0, 16'h8000, hit(27'h0000000), "wrap32_02");
    rom_size = 27'h00000;
    wr(16'hA000, 8'h00);
    rd(0, 16'h8000, miss(), "nr0_unmapped");

    rom_size = 27'h20000;
    reset_pulse();
    blk_id = 1'b1;
    wr(16'h6000, 8'h03);
    blk_id = 1'b0;
    rd(0, 16'h4000, hit(27'h0000000), "id0_keep");
    blk_id = 1'b1;
    rd(0, 16'h4000, hit(27'h000C000), "id1_w0");
    rd(0, 16'h8000, hit(27'h0004000), "id1_w1");
    blk_id = 1'b0;

    rd(0, 16'h0000, miss(), "page_lo");
    rd(0, 16'hC000, miss(), "page_hi");
    enable = 1'b0;
    rd(0, 16'h4000, miss(), "disabled");
    enable = 1'b1;
    set_bus(16'h4000, 8'h00, 1'b1, 1'b0);
    cpu_mreq = 1'b0;
    expect_out(0, miss(), "no_mreq");
    step();
    wr(16'hE000, 8'h07);
    rd(0, 16'h8000, hit(27'h0004000), "oor_wr");

    // reset asserted mid-write discards the write
    set_bus(16'h6000, 8'h06, 1'b0, 1'b1);
    #2 reset_n = 1'b0;
    step();
    set_bus(16'h4000, 8'h00, 1'b1, 1'b0);
    expect_out(0, miss(), "rst_mid_gate");
    step();
    reset_n = 1'b1;
    rd(0, 16'h4000, hit(27'h0000000), "rst_discard");

    // 8KB banks, pages 2..5
    reset_pulse();
    rd(1, 16'h6010, hit(27'h0002010), "b13_rst_w1");
    wr(16'hB000, 8'h0A);
    rd(1, 16'hA010, hit(27'h0014010), "b13_w3");
    wr(16'h3000, 8'h07);
    rd(1, 16'h2000, miss(), "b13_pg1");
    rd(1, 16'h4000, hit(27'h0000000), "b13_w0");

`ifdef MAPPER_SRAM_EN
    reset_pulse();
    wr(16'hA000, 8'h80);
    rd(0, 16'h8010, sram_hit(14'h0010), "sram_rd");
    set_bus(16'h8010, 8'h55, 1'b0, 1'b1);
    expect_out(0, sram_hit(14'h0010), "sram_wr");
    step();
    set_bus(16'h0000, 8'h00, 1'b0, 1'b0);
    step();
    wr(16'hA000, 8'h01);
    rd(0, 16'h8010, hit(27'h0004010), "sram_off");
`endif

    set_bus(16'h0000, 8'h00, 1'b0, 1'b0);
    step();
    step();
    check_eq("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
